// File: rtl/pmbist_march_engine_pkg.sv
// pmbist_march_engine_pkg: instruction layout, address modes, FSM states and the
// byte-pattern helper shared by the march engine and its address generator.
package pmbist_march_engine_pkg;

    localparam int SCAN_WIDTH = 22;

    typedef enum logic [1:0] {
        ADMD_FULL   = 2'd0,
        ADMD_EVEN   = 2'd1,
        ADMD_ODD    = 2'd2,
        ADMD_SINGLE = 2'd3
    } admd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Scan word, MSB first; op k uses op[k] and pol[k]
    typedef struct packed {
        logic       updwn;
        logic [3:0] op;
        logic [3:0] pol;
        logic [1:0] no;
        logic [7:0] data;
        logic       w;
        admd_e      admd;
    } instr_t;

    function automatic logic [7:0] op_pattern(input logic [7:0] data, input logic inv);
        return data ^ {8{inv}};
    endfunction

endpackage

// File: rtl/pmbist_march_engine_addr_gen.sv
// pmbist_addr_gen: address sequencer for one march element; loads the first legal
// address for the mode/direction and steps toward the last one without wrapping.
module pmbist_addr_gen
    import pmbist_march_engine_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  admd_e             mode_i,
    input  logic              down_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              odd_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] MAX_A = '1;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] lo_s;
    logic [ADDR_W-1:0] hi_s;
    logic [ADDR_W-1:0] stride_s;

    // Legal address window and stride of the selected mode
    always_comb begin
        lo_s     = '0;
        hi_s     = MAX_A;
        stride_s = ADDR_W'(1);
        case (mode_i)
            ADMD_FULL: begin
                lo_s     = '0;
                hi_s     = MAX_A;
                stride_s = ADDR_W'(1);
            end
            ADMD_EVEN: begin
                lo_s     = '0;
                hi_s     = MAX_A - ADDR_W'(1);
                stride_s = ADDR_W'(2);
            end
            ADMD_ODD: begin
                lo_s     = ADDR_W'(1);
                hi_s     = MAX_A;
                stride_s = ADDR_W'(2);
            end
            ADMD_SINGLE: begin
                lo_s     = down_i ? MAX_A : '0;
                hi_s     = down_i ? MAX_A : '0;
                stride_s = '0;
            end
            default: begin
                lo_s     = '0;
                hi_s     = MAX_A;
                stride_s = ADDR_W'(1);
            end
        endcase
    end

    assign last_o = (addr_q == (down_i ? lo_s : hi_s));
    assign addr_o = addr_q;
    assign odd_o  = addr_q[0];

    // Address register: load the first address, then step until the last one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
        end else if (load_i) begin
            addr_q <= down_i ? hi_s : lo_s;
        end else if (step_i && !last_o) begin
            addr_q <= down_i ? (addr_q - stride_s) : (addr_q + stride_s);
        end
    end

endmodule

// File: rtl/pmbist_march_engine.sv
// pmbist_march_engine: executes one scan-loaded march element over an SRAM port and
// checks read data. Define PMBIST_FAIL_LOG_EN to build the fail counter and first-fail latch.
module pmbist_march_engine
    import pmbist_march_engine_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SCAN_WIDTH-1:0] scan,
    input  logic                  ts,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  passfail,
    output logic [CNT_W-1:0]      fail_cnt,
    output logic [ADDR_W-1:0]     fail_addr
);

    state_e            state_q;
    instr_t            instr_q;
    instr_t            scan_s;
    logic              ts_q;
    logic [1:0]        op_idx_q;
    logic [1:0]        drain_cnt_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] exp_q;
    logic              mem_we_q;
    logic              mem_re_q;
    logic              busy_q;
    logic              done_q;
    logic              passfail_q;

    logic              start_s;
    logic              last_op_s;
    logic              op_we_s;
    logic [DATA_W-1:0] op_data_s;
    logic              ag_step_s;
    logic              ag_last_s;
    logic              ag_odd_s;
    logic              ag_down_s;
    admd_e             ag_mode_s;
    logic [ADDR_W-1:0] ag_addr_s;
    logic              miscmp_s;

    logic              rv_q   [RD_LAT];
    logic [DATA_W-1:0] rexp_q [RD_LAT];

    assign scan_s  = instr_t'(scan);
    assign start_s = ts && !ts_q && (state_q == ST_IDLE);

    // Current op decode; the address generator sees the scan word during the load cycle
    always_comb begin
        op_we_s   = instr_q.op[op_idx_q];
        op_data_s = {(DATA_W/8){op_pattern(instr_q.data,
                                           (instr_q.w & ag_odd_s) ^ instr_q.pol[op_idx_q])}};
        last_op_s = (op_idx_q == instr_q.no);
        ag_step_s = (state_q == ST_RUN) && last_op_s;
        ag_mode_s = start_s ? scan_s.admd  : instr_q.admd;
        ag_down_s = start_s ? scan_s.updwn : instr_q.updwn;
    end

    pmbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .load_i (start_s),
        .step_i (ag_step_s),
        .mode_i (ag_mode_s),
        .down_i (ag_down_s),
        .addr_o (ag_addr_s),
        .odd_o  (ag_odd_s),
        .last_o (ag_last_s)
    );

    // Engine FSM with registered memory strobes, busy and done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            ts_q        <= 1'b0;
            op_idx_q    <= 2'd0;
            drain_cnt_q <= 2'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            exp_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            ts_q     <= ts;
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= (state_q == ST_RUN) || (state_q == ST_DRAIN);
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        instr_q  <= scan_s;
                        op_idx_q <= 2'd0;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    mem_addr_q <= ag_addr_s;
                    mem_we_q   <= op_we_s;
                    mem_re_q   <= !op_we_s;
                    exp_q      <= op_data_s;
                    if (op_we_s) begin
                        mem_wdata_q <= op_data_s;
                    end
                    if (last_op_s) begin
                        op_idx_q <= 2'd0;
                        if (ag_last_s) begin
                            drain_cnt_q <= 2'd0;
                            state_q     <= ST_DRAIN;
                        end
                    end else begin
                        op_idx_q <= op_idx_q + 2'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == 2'(RD_LAT - 1)) begin
                        state_q <= ST_DONE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 2'd1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Expected-data pipeline; the last stage lines up with mem_rdata
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                rv_q[i]   <= 1'b0;
                rexp_q[i] <= '0;
            end
        end else begin
            rv_q[0]   <= mem_re_q;
            rexp_q[0] <= exp_q;
            for (int i = 1; i < RD_LAT; i++) begin
                rv_q[i]   <= rv_q[i-1];
                rexp_q[i] <= rexp_q[i-1];
            end
        end
    end

    assign miscmp_s = rv_q[RD_LAT-1] && (mem_rdata != rexp_q[RD_LAT-1]);

    // Sticky fail flag, cleared by an accepted start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            passfail_q <= 1'b0;
        end else if (start_s) begin
            passfail_q <= 1'b0;
        end else if (miscmp_s) begin
            passfail_q <= 1'b1;
        end
    end

`ifdef PMBIST_FAIL_LOG_EN
    logic [ADDR_W-1:0] raddr_q [RD_LAT];
    logic [CNT_W-1:0]  fail_cnt_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic              logged_q;

    // Read-address pipeline kept beside the expected data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                raddr_q[i] <= '0;
            end
        end else begin
            raddr_q[0] <= mem_addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                raddr_q[i] <= raddr_q[i-1];
            end
        end
    end

    // Saturating miscompare counter and first-fail address latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fail_cnt_q  <= '0;
            fail_addr_q <= '0;
            logged_q    <= 1'b0;
        end else if (start_s) begin
            fail_cnt_q  <= '0;
            fail_addr_q <= '0;
            logged_q    <= 1'b0;
        end else if (miscmp_s) begin
            if (fail_cnt_q != {CNT_W{1'b1}}) begin
                fail_cnt_q <= fail_cnt_q + CNT_W'(1);
            end
            if (!logged_q) begin
                fail_addr_q <= raddr_q[RD_LAT-1];
                logged_q    <= 1'b1;
            end
        end
    end

    assign fail_cnt  = fail_cnt_q;
    assign fail_addr = fail_addr_q;
`else
    assign fail_cnt  = '0;
    assign fail_addr = '0;
`endif

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign passfail  = passfail_q;

endmodule
